cv32e40p_secded_decoder_pipe: RTL and testbench
===============================================

// Module: cv32e40p_secded_decoder_pipe
// PURPOSE
//  Parametrised SEC-DED (Hamming + overall parity) check/correct pipeline.
//  It is the read-side companion of the team's Hamming encoder, generalised to any DATA_W.
//  It sits between an ECC-protected memory/register file and its consumer, with valid/ready on both sides.
//  It corrects single-bit errors, flags double-bit errors, and keeps saturating error counters.
// PARAMETERS
//  DATA_W   32  payload width (>=4)
//  PAR_W    derived: smallest P with 2**P >= DATA_W+P+1 (6 for 32)
//  CODE_W   derived: DATA_W+PAR_W+1 (39 for 32)
//  CNT_W    16  width of each error counter
// PORTS
//  clk         in   1        clock
//  rst_n       in   1        async active-low reset
//  in_valid_i  in   1        input codeword valid
//  in_ready_o  out  1        decoder can accept
//  in_code_i   in   CODE_W   codeword, layout below
//  out_valid_o out  1        result valid
//  out_ready_i in   1        consumer accepts
//  out_data_o  out  DATA_W   corrected payload
//  out_code_o  out  CODE_W   corrected codeword (for scrub write-back)
//  out_ce_o    out  1        correctable error on this result
//  out_ue_o    out  1        uncorrectable error on this result
//  out_synd_o  out  PAR_W    raw syndrome of this result
//  cnt_clr_i   in   1        synchronous clear of both counters
//  cnt_ce_o    out  CNT_W    saturating count of accepted CE results
//  cnt_ue_o    out  CNT_W    saturating count of accepted UE results
// BEHAVIOUR
//  Code layout:
//   - bit (2**k)-1 holds parity k, k=0..PAR_W-1.
//   - Data bits fill the remaining positions below CODE_W-1 in ascending order.
//   - bit CODE_W-1 = XOR of bits [CODE_W-2:0].
//   - For DATA_W=32, bits [37:0] equal the existing 38-bit encoder output.
//  Syndrome: s[k] = XOR of code bits i (i<CODE_W-1) where bit k of (i+1) is set.
//   p = XOR of all CODE_W bits.
//  Classification:
//   - s==0, p==0: clean.
//   - p==1, s==0: error in the overall parity bit. Flip bit CODE_W-1; ce=1.
//   - p==1, 1<=s<=CODE_W-1: flip bit s-1; ce=1.
//   - p==1, s>CODE_W-1: ue=1; no flip.
//   - p==0, s!=0: ue=1; no flip; data passed through raw.
//  Pipeline: S1 registers the input and computes s/p; S2 registers the corrected result.
//   Latency is 2 cycles from the accepting in-handshake to out_valid_o when out_ready_i is held 1.
//  Handshake:
//   - Each stage loads when it is empty or when its contents move downstream in the same cycle.
//   - in_ready_o = !s1_valid | s1_moves.
//   - Full throughput is 1/cycle.
//   - Output payload and flags are stable while out_valid_o & !out_ready_i.
//   - out_valid_o never drops without a handshake.
//  Counters:
//   - Increment only on an output handshake with ce or ue set.
//   - They saturate at all-ones.
//   - cnt_clr_i wins over a simultaneous increment; the result is 0.
//  Reset: all valids 0, all flags 0, syndrome 0, data/code 0, counters 0. in_ready_o=1 after reset.
//  A reset mid-stream drops in-flight words silently.
// STRUCTURE
//  Package cv32e40p_ecc_pkg holds:
//   - function ecc_par_w(DATA_W), constant localparams, and function ecc_encode (used by the TB too).
//   - typedef ecc_status_e {ECC_OK, ECC_CE, ECC_UE}.
//  Sub-module cv32e40p_ecc_syndrome is combinational and computes s, p and the correction mask.
//  It is instantiated once, in S1.
// TESTING (DATA_W=32, CODE_W=39)
//  - Clean word: in 39'h40_0000_0007 -> 2 cycles later data 32'h1, ce=0, ue=0, synd=0.
//  - Single error: 39'h40_0000_0003 (bit2 flipped) -> data 32'h1, code 39'h40_0000_0007, ce=1, synd=3.
//  - Overall-parity error: 39'h00_0000_0007 -> data 32'h1, ce=1, synd=0.
//  - Double error: 39'h40_0000_0004 (bits0,1 flipped) -> ue=1, ce=0, synd=3, cnt_ue_o=1.
//  - Backpressure: stream 4 words with out_ready_i=0 for 5 cycles.
//   in_ready_o drops after 2 words are accepted. Outputs stay stable. Order is preserved, no loss.
//  - Counter: CNT_W=2 with 5 CE words -> cnt_ce_o=3; cnt_clr_i on a CE handshake -> 0.
//   Async reset mid-stream -> out_valid_o=0 immediately.

Source files
------------

// File: rtl/cv32e40p_ecc_pkg.sv
// Shared SEC-DED code geometry, encoder and status type for the ECC
// read/write paths.
package cv32e40p_ecc_pkg;

    typedef enum logic [1:0] {
        ECC_OK,
        ECC_CE,
        ECC_UE
    } ecc_status_e;

    localparam int ECC_MAX_DATA_W = 64;
    localparam int ECC_MAX_CODE_W = 72;
    localparam int ECC_IDX_W      = 7;
    localparam int ECC_POS_SCAN   = 128;

    function automatic bit ecc_is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int ecc_par_w(input int data_w);
        int p;
        p = 0;
        for (int q = 1; q < 16; q++) begin
            if (p == 0 && (1 << q) >= data_w + q + 1) begin
                p = q;
            end
        end
        return p;
    endfunction

    // Code position of payload bit d: the d-th slot whose (index+1)
    // is not a power of two.
    function automatic int ecc_data_pos(input int d);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int i = 0; i < ECC_POS_SCAN; i++) begin
            if (!ecc_is_pow2(i + 1)) begin
                if (n == d) begin
                    pos = i;
                end
                n++;
            end
        end
        return pos;
    endfunction

    function automatic logic [ECC_MAX_CODE_W-1:0] ecc_encode(
        input logic [ECC_MAX_DATA_W-1:0] data,
        input int                        data_w
    );
        logic [ECC_MAX_CODE_W-1:0] code;
        logic [ECC_IDX_W-1:0]      idx;
        logic                      acc;
        int                        par_w;
        int                        code_w;
        par_w  = ecc_par_w(data_w);
        code_w = data_w + par_w + 1;
        code   = '0;
        for (int d = 0; d < ECC_MAX_DATA_W; d++) begin
            if (d < data_w) begin
                idx       = ECC_IDX_W'(ecc_data_pos(d));
                code[idx] = data[d];
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (k < par_w) begin
                acc = 1'b0;
                for (int i = 0; i < ECC_MAX_CODE_W; i++) begin
                    if (i < code_w - 1 && (((i + 1) >> k) & 1) != 0) begin
                        acc = acc ^ code[i];
                    end
                end
                idx       = ECC_IDX_W'((1 << k) - 1);
                code[idx] = acc;
            end
        end
        acc = 1'b0;
        for (int i = 0; i < ECC_MAX_CODE_W; i++) begin
            if (i < code_w - 1) begin
                acc = acc ^ code[i];
            end
        end
        idx       = ECC_IDX_W'(code_w - 1);
        code[idx] = acc;
        return code;
    endfunction

endpackage

// File: rtl/cv32e40p_ecc_syndrome.sv
// Combinational SEC-DED checker: Hamming syndrome, overall parity and
// the single-bit correction mask for one codeword.
module cv32e40p_ecc_syndrome
    import cv32e40p_ecc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PAR_W  = ecc_par_w(DATA_W),
    parameter int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [PAR_W-1:0]  synd_o,
    output logic              par_o,
    output logic [CODE_W-1:0] mask_o
);

    logic [PAR_W-1:0] s;

    always_comb begin
        s = '0;
        for (int k = 0; k < PAR_W; k++) begin
            for (int i = 0; i < CODE_W - 1; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    s[k] = s[k] ^ code_i[i];
                end
            end
        end
    end

    assign synd_o = s;
    assign par_o  = ^code_i;

    // Syndromes past the last code position cannot come from one flip.
    always_comb begin
        mask_o = '0;
        if (par_o) begin
            if (s == '0) begin
                mask_o[CODE_W-1] = 1'b1;
            end else if (int'(s) <= CODE_W - 1) begin
                for (int i = 0; i < CODE_W - 1; i++) begin
                    mask_o[i] = (int'(s) == i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/cv32e40p_secded_decoder_pipe.sv
// Two-stage SEC-DED check/correct pipeline with valid/ready on both
// sides and saturating CE/UE event counters.
module cv32e40p_secded_decoder_pipe
    import cv32e40p_ecc_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = ecc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CODE_W-1:0] in_code_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CODE_W-1:0] out_code_o,
    output logic              out_ce_o,
    output logic              out_ue_o,
    output logic [PAR_W-1:0]  out_synd_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  cnt_ce_o,
    output logic [CNT_W-1:0]  cnt_ue_o
);

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic [CODE_W-1:0] s2_code_q, s2_code_d;
    logic              s2_ce_q, s2_ce_d;
    logic              s2_ue_q, s2_ue_d;
    logic [PAR_W-1:0]  s2_synd_q, s2_synd_d;
    logic [CNT_W-1:0]  cnt_ce_q, cnt_ce_d;
    logic [CNT_W-1:0]  cnt_ue_q, cnt_ue_d;

    logic              in_fire;
    logic              s1_moves;
    logic              s2_moves;
    logic [PAR_W-1:0]  s1_synd;
    logic              s1_par;
    logic [CODE_W-1:0] s1_mask;
    logic [CODE_W-1:0] s1_fixed;
    logic [DATA_W-1:0] s1_data;
    ecc_status_e       s1_status;

    assign s2_moves   = s2_valid_q & out_ready_i;
    assign s1_moves   = s1_valid_q & (~s2_valid_q | s2_moves);
    assign in_ready_o = ~s1_valid_q | s1_moves;
    assign in_fire    = in_valid_i & in_ready_o;

    cv32e40p_ecc_syndrome #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .CODE_W (CODE_W)
    ) u_syndrome (
        .code_i (s1_code_q),
        .synd_o (s1_synd),
        .par_o  (s1_par),
        .mask_o (s1_mask)
    );

    // A UE leaves the mask empty, so the payload is the raw word.
    assign s1_fixed = s1_code_q ^ s1_mask;

    for (genvar d = 0; d < DATA_W; d++) begin : g_extract
        localparam int POS = ecc_data_pos(d);
        assign s1_data[d] = s1_fixed[POS];
    end

    always_comb begin
        s1_status = ECC_OK;
        if (|s1_mask) begin
            s1_status = ECC_CE;
        end else if (s1_par | (|s1_synd)) begin
            s1_status = ECC_UE;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_code_d  = in_code_i;
        end else if (s1_moves) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_code_d  = s2_code_q;
        s2_ce_d    = s2_ce_q;
        s2_ue_d    = s2_ue_q;
        s2_synd_d  = s2_synd_q;
        if (s1_moves) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_data;
            s2_code_d  = s1_fixed;
            s2_ce_d    = (s1_status == ECC_CE);
            s2_ue_d    = (s1_status == ECC_UE);
            s2_synd_d  = s1_synd;
        end else if (s2_moves) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_ce_d = cnt_ce_q;
        cnt_ue_d = cnt_ue_q;
        if (cnt_clr_i) begin
            cnt_ce_d = '0;
            cnt_ue_d = '0;
        end else if (s2_moves) begin
            if (s2_ce_q && cnt_ce_q != '1) begin
                cnt_ce_d = cnt_ce_q + 1'b1;
            end
            if (s2_ue_q && cnt_ue_q != '1) begin
                cnt_ue_d = cnt_ue_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_code_q  <= '0;
            s2_ce_q    <= 1'b0;
            s2_ue_q    <= 1'b0;
            s2_synd_q  <= '0;
            cnt_ce_q   <= '0;
            cnt_ue_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_code_q  <= s2_code_d;
            s2_ce_q    <= s2_ce_d;
            s2_ue_q    <= s2_ue_d;
            s2_synd_q  <= s2_synd_d;
            cnt_ce_q   <= cnt_ce_d;
            cnt_ue_q   <= cnt_ue_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = s2_data_q;
    assign out_code_o  = s2_code_q;
    assign out_ce_o    = s2_ce_q;
    assign out_ue_o    = s2_ue_q;
    assign out_synd_o  = s2_synd_q;
    assign cnt_ce_o    = cnt_ce_q;
    assign cnt_ue_o    = cnt_ue_q;

endmodule

// File: tb/tb_cv32e40p_secded_decoder_pipe.sv
// Scoreboard bench for the SEC-DED decoder pipeline (DATA_W=32,
// narrow counters so saturation is reachable).
module tb_cv32e40p_secded_decoder_pipe;
    import cv32e40p_ecc_pkg::*;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 6;
    localparam int CODE_W = 39;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CODE_W-1:0] code;
        logic              ce;
        logic              ue;
        logic [PAR_W-1:0]  synd;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CODE_W-1:0] out_code;
    logic              out_ce;
    logic              out_ue;
    logic [PAR_W-1:0]  out_synd;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt_ce;
    logic [CNT_W-1:0]  cnt_ue;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   failures;
    int   accepted;
    int   mce;
    int   mue;
    bit   done;

    logic              st_prev;
    logic [CODE_W-1:0] st_code;
    logic [DATA_W-1:0] st_data;
    logic [1:0]        st_flags;

    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] bd;
    logic [DATA_W-1:0] bp_first;
    int                nf;
    int                fa;
    int                fb;

    cv32e40p_secded_decoder_pipe #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_code_i   (in_code),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_code_o  (out_code),
        .out_ce_o    (out_ce),
        .out_ue_o    (out_ue),
        .out_synd_o  (out_synd),
        .cnt_clr_i   (cnt_clr),
        .cnt_ce_o    (cnt_ce),
        .cnt_ue_o    (cnt_ue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CODE_W-1:0] enc(input logic [DATA_W-1:0] d);
        return CODE_W'(ecc_encode(ECC_MAX_DATA_W'(d), DATA_W));
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = c[6'(ecc_data_pos(i))];
        end
        return d;
    endfunction

    // Syndrome contribution of a flip at position a.
    function automatic int sp(input int a);
        return (a == CODE_W - 1) ? 0 : a + 1;
    endfunction

    function automatic logic [CODE_W-1:0] corrupt(input logic [DATA_W-1:0] d,
                                                  input int n, input int a,
                                                  input int b);
        logic [CODE_W-1:0] c;
        c = enc(d);
        if (n >= 1) c = c ^ (CODE_W'(1) << a);
        if (n == 2) c = c ^ (CODE_W'(1) << b);
        return c;
    endfunction

    function automatic exp_t ex(input logic [DATA_W-1:0] d,
                                input logic [CODE_W-1:0] c,
                                input logic ce, input logic ue,
                                input logic [PAR_W-1:0] s);
        exp_t e;
        e.data = d;
        e.code = c;
        e.ce   = ce;
        e.ue   = ue;
        e.synd = s;
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic [DATA_W-1:0] d,
                                    input int n, input int a, input int b);
        logic [CODE_W-1:0] c;
        c = corrupt(d, n, a, b);
        if (n == 0) return ex(d, c, 1'b0, 1'b0, '0);
        if (n == 1) return ex(d, enc(d), 1'b1, 1'b0, PAR_W'(sp(a)));
        return ex(extract(c), c, 1'b0, 1'b1, PAR_W'(sp(a) ^ sp(b)));
    endfunction

    task automatic send(input logic [CODE_W-1:0] code, input exp_t e);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_code  = code;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                accepted++;
                ok = 1'b1;
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                mce     = 0;
                mue     = 0;
                st_prev = 1'b0;
            end else begin
                chk("cnt_ce", 64'(cnt_ce), 64'(mce));
                chk("cnt_ue", 64'(cnt_ue), 64'(mue));
                if (st_prev) begin
                    chk("stall_valid", 64'(out_valid), 64'(1));
                    chk("stall_code", 64'(out_code), 64'(st_code));
                    chk("stall_data", 64'(out_data), 64'(st_data));
                    chk("stall_flags", 64'({out_ce, out_ue}), 64'(st_flags));
                end
                st_prev  = out_valid & ~out_ready;
                st_code  = out_code;
                st_data  = out_data;
                st_flags = {out_ce, out_ue};
                mon_e    = ex('0, '0, 1'b0, 1'b0, '0);
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out", 64'(1), 64'(0));
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(mon_e.data));
                        chk("out_code", 64'(out_code), 64'(mon_e.code));
                        chk("out_ce", 64'(out_ce), 64'(mon_e.ce));
                        chk("out_ue", 64'(out_ue), 64'(mon_e.ue));
                        chk("out_synd", 64'(out_synd), 64'(mon_e.synd));
                    end
                end
                if (cnt_clr) begin
                    mce = 0;
                    mue = 0;
                end else begin
                    if (mon_e.ce && mce < CNT_MAX) mce++;
                    if (mon_e.ue && mue < CNT_MAX) mue++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        checks    = 0;
        failures  = 0;
        accepted  = 0;
        done      = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_code", 64'(out_code), 64'(0));
        chk("rst_flags", 64'({out_ce, out_ue}), 64'(0));
        chk("rst_synd", 64'(out_synd), 64'(0));
        chk("rst_cnt", 64'({cnt_ce, cnt_ue}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known vectors and latency
        @(posedge clk);
        #1;
        send(39'h40_0000_0007, ex(32'h1, 39'h40_0000_0007, 1'b0, 1'b0, 6'd0));
        chk("lat_c1", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("lat_c2", 64'(out_valid), 64'(1));
        send(39'h40_0000_0003, ex(32'h1, 39'h40_0000_0007, 1'b1, 1'b0, 6'd3));
        send(39'h00_0000_0007, ex(32'h1, 39'h40_0000_0007, 1'b1, 1'b0, 6'd0));
        send(39'h40_0000_0004, ex(32'h1, 39'h40_0000_0004, 1'b0, 1'b1, 6'd3));
        repeat (4) @(posedge clk);
        #1;
        chk("vec_cnt_ue", 64'(cnt_ue), 64'(1));
        chk("vec_cnt_ce", 64'(cnt_ce), 64'(2));

        // Random words, random flips, random backpressure
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    rd = $urandom;
                    nf = int'($urandom_range(0, 2));
                    fa = int'($urandom_range(0, CODE_W - 1));
                    fb = (fa + int'($urandom_range(1, CODE_W - 1))) % CODE_W;
                    send(corrupt(rd, nf, fa, fb), mk_exp(rd, nf, fa, fb));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Stall the consumer for 5 cycles while 4 words are offered
        out_ready = 1'b0;
        accepted  = 0;
        bp_first  = 32'hCAFE_0000;
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    bd = bp_first + 32'(n);
                    send(enc(bd), mk_exp(bd, 0, 0, 0));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_accepted", 64'(accepted), 64'(2));
                chk("bp_in_ready", 64'(in_ready), 64'(0));
                chk("bp_out_valid", 64'(out_valid), 64'(1));
                chk("bp_head", 64'(out_data), 64'(bp_first));
                out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Counter saturation, then clear against a CE handshake
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("clr_idle", 64'(cnt_ce), 64'(0));
        for (int n = 0; n < 5; n++) begin
            rd = $urandom;
            fa = int'($urandom_range(0, CODE_W - 1));
            send(corrupt(rd, 1, fa, 0), mk_exp(rd, 1, fa, 0));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("cnt_sat", 64'(cnt_ce), 64'(3));
        out_ready = 1'b0;
        rd = $urandom;
        send(corrupt(rd, 1, 5, 0), mk_exp(rd, 1, 5, 0));
        @(posedge clk);
        #1;
        chk("clr_ce_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("clr_wins", 64'(cnt_ce), 64'(0));

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        rd = $urandom;
        send(enc(rd), mk_exp(rd, 0, 0, 0));
        rd = $urandom;
        send(enc(rd), mk_exp(rd, 1, 7, 0) );
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_cnt", 64'({cnt_ce, cnt_ue}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        rd = 32'h0000_0001;
        send(enc(rd), ex(rd, 39'h40_0000_0007, 1'b0, 1'b0, 6'd0));
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
